adder_32: RTL and testbench

- 32-bit unsigned/two's-complement binary adder with carry-in and carry-out.
- Operands are added by a two-level carry-lookahead network: eight 4-bit CLA groups plus a group-level lookahead unit.
- Result and carry are registered once.
- Used as the shared arithmetic primitive under the ALU and address-increment paths.

---
 rtl/adder_32.sv | 96 +++++++++
 tb/tb_adder_32.sv | 138 +++++++++++++
 2 files changed

// File: rtl/adder_32.sv
// 32-bit two-level carry-lookahead adder with one register stage on sum and carry.
// Define OVERFLOW_FLAG_EN to add the registered signed-overflow output ovf.
module adder_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        c0,
  output logic [31:0] out,
  output logic        c32
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic        ovf
`endif
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] carry;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [31:0] sum;

  // Sum-of-products carry into group k+1: each group generate is qualified
  // by the propagates of all groups above it, plus c0 through every group.
  function automatic logic group_carry(
    input logic [7:0] gg,
    input logic [7:0] pp,
    input logic       cin,
    input int         k
  );
    logic acc;
    logic chain;
    acc   = 1'b0;
    chain = 1'b1;
    for (int j = 7; j >= 0; j--) begin
      if (j <= k) begin
        acc   = acc | (chain & gg[j]);
        chain = chain & pp[j];
      end
    end
    return acc | (chain & cin);
  endfunction

  assign g = A & B;
  assign p = A ^ B;
  assign carry[0] = c0;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gen_group
      localparam int BASE = 4 * gi;
      logic [3:0] gl;
      logic [3:0] pl;
      logic       ci;

      assign gl = g[BASE +: 4];
      assign pl = p[BASE +: 4];
      assign ci = carry[BASE];

      assign carry[BASE + 1] = gl[0] | (pl[0] & ci);
      assign carry[BASE + 2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
      assign carry[BASE + 3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                             | (pl[2] & pl[1] & pl[0] & ci);

      assign grp_g[gi] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                       | (pl[3] & pl[2] & pl[1] & gl[0]);
      assign grp_p[gi] = &pl;

      // Group boundary carries come from the second level, never from ripple.
      assign carry[BASE + 4] = group_carry(grp_g, grp_p, c0, gi);
    end

    for (gi = 0; gi < 32; gi++) begin : gen_sum
      assign sum[gi] = p[gi] ^ carry[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      out <= 32'd0;
      c32 <= 1'b0;
    end else begin
      out <= sum;
      c32 <= carry[32];
    end
  end

`ifdef OVERFLOW_FLAG_EN
  always_ff @(posedge clock) begin
    if (reset) ovf <= 1'b0;
    else       ovf <= carry[31] ^ carry[32];
  end
`endif

endmodule

// File: tb/tb_adder_32.sv
// Scoreboard bench for adder_32: directed boundary cases plus random vectors
// against a 33-bit arithmetic reference, one result expected per clock.
module tb_adder_32;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        c0;
  logic [31:0] out;
  logic        c32;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic stim_done  = 1'b0;

  adder_32 dut (
    .clock (clock),
    .reset (reset),
    .A     (A),
    .B     (B),
    .c0    (c0),
    .out   (out),
    .c32   (c32)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of stimulus on the falling edge and queue what the
  // following rising edge must register.
  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input string tag);
    exp_t e;
    logic [32:0] full;
    @(negedge clock);
    reset = r;
    A     = a;
    B     = b;
    c0    = c;
    full  = {1'b0, a} + {1'b0, b} + {32'd0, c};
    e.tag = tag;
    if (r) begin
      e.sum  = 32'd0;
      e.cout = 1'b0;
      e.v    = 1'b0;
    end else begin
      e.sum  = full[31:0];
      e.cout = full[32];
      e.v    = (a[31] == b[31]) && (full[31] != a[31]);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: the adder presents a result every cycle, so every rising edge
  // with an outstanding expectation is a comparison.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (out !== e.sum || c32 !== e.cout) begin
          miscompares++;
          $display("FAIL %s: out=%h c32=%b, required out=%h c32=%b",
                   e.tag, out, c32, e.sum, e.cout);
        end
`ifdef OVERFLOW_FLAG_EN
        if (ovf !== e.v) begin
          miscompares++;
          $display("FAIL %s ovf: got %b, required %b", e.tag, ovf, e.v);
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    A     = 32'd0;
    B     = 32'd0;
    c0    = 1'b0;

    apply(1'b1, 32'd0, 32'd0, 1'b0, "reset0");
    apply(1'b1, 32'd0, 32'd0, 1'b0, "reset1");
    for (int i = 0; i < 11; i++) apply(1'b0, 32'd128, 32'd127, 1'b0, "hold_255");

    apply(1'b0, 32'hFFFF_FFFF, 32'd1,        1'b0, "wrap_ff_1");
    apply(1'b0, 32'hFFFF_FFFF, 32'd0,        1'b1, "prop_full");
    apply(1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, "prop_alt");
    apply(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "all_ones_cin");
    apply(1'b0, 32'd0,         32'd0,        1'b0, "all_zero");
    apply(1'b0, 32'h7FFF_FFFF, 32'd1,        1'b0, "pos_ovf");
    apply(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "neg_ovf");

    apply(1'b0, 32'd5, 32'd6, 1'b0, "pre_rst_11");
    apply(1'b1, 32'd5, 32'd6, 1'b0, "mid_rst");
    apply(1'b0, 32'd5, 32'd6, 1'b0, "post_rst_11");

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      // Bias some vectors toward long propagate chains.
      if ((i % 8) == 0) rb = ~ra;
      apply(1'b0, ra, rb, 1'($urandom_range(0, 1)), "random");
    end

    stim_done = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
